// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   state_t   : controller FSM encoding (RUN = normal, HOLD = second stall
//               cycle of a branch that depends on a load in EX)
//   CNT_W     : width of the stall / flush event counters
//   REG_W     : register-specifier width
//   hazard_t  : the individual hazard conditions evaluated in RUN
//   reg_match : "producer dst equals consumer src, and src is not $0"
package hazard_pkg;

  localparam int CNT_W = 16;
  localparam int REG_W = 5;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One flag per hazard class; priority is resolved in the controller.
  typedef struct packed {
    logic br_load_ex;   // branch needs a value a load in EX has not fetched yet
    logic br_alu_ex;    // branch needs an ALU result still in EX
    logic br_load_mem;  // branch needs a value a load in MEM is still reading
    logic load_use;     // non-branch consumer of a load in EX
  } hazard_t;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return (dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and the hazard
// controller.
//   Inputs to the controller (driven by the pipeline, modport master):
//     IF_ID_rs / IF_ID_rt   source registers of the instruction in ID
//     uses_rt               ID instruction actually reads rt
//     branch / branch_taken ID-resolved branch and its compare result
//     ID_EX_mem_read / ID_EX_reg_write / ID_EX_rd   EX-stage producer
//     EX_MEM_mem_read / EX_MEM_rd                    MEM-stage producer
//   Outputs of the controller (modport slave):
//     pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush   pipeline controls
//     stall_count, flush_count                           saturating counters
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] IF_ID_rs;
  logic [REG_W-1:0] IF_ID_rt;
  logic             uses_rt;
  logic             branch;
  logic             branch_taken;
  logic             ID_EX_mem_read;
  logic             ID_EX_reg_write;
  logic [REG_W-1:0] ID_EX_rd;
  logic             EX_MEM_mem_read;
  logic [REG_W-1:0] EX_MEM_rd;

  logic             pc_write;
  logic             IF_ID_write;
  logic             ID_EX_bubble;
  logic             IF_ID_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side.
  modport master (
    output IF_ID_rs, IF_ID_rt, uses_rt, branch, branch_taken,
           ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd,
           EX_MEM_mem_read, EX_MEM_rd,
    input  pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
           stall_count, flush_count
  );

  // Hazard controller side.
  modport slave (
    input  IF_ID_rs, IF_ID_rt, uses_rt, branch, branch_taken,
           ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd,
           EX_MEM_mem_read, EX_MEM_rd,
    output pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
           stall_count, flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
//   clk   : clock, counts on rising edge
//   rstn  : asynchronous active-low clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush controller for a 5-stage pipeline whose branches
// resolve in ID with forwarded operands.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   hz   : hazard_ctrl_if.slave -- ID/EX/MEM hazard inputs, pipeline control
//          outputs (pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush) and the
//          saturating stall / flush counters.
// Control outputs are purely combinational from state and inputs so the
// pipeline sees them in the same cycle the hazard appears.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  hazard_ctrl_if.slave hz
);

  state_t  state_reg;
  state_t  state_next;
  hazard_t hazard;
  logic    dep_ex;
  logic    dep_mem;
  logic    stall;
  logic    flush;

  // Dependency of the ID instruction on the EX / MEM destination. rt only
  // counts when the instruction really reads it (I-type ALU ops and loads
  // carry a destination in the rt field).
  assign dep_ex  = reg_match(hz.ID_EX_rd, hz.IF_ID_rs) ||
                   (hz.uses_rt && reg_match(hz.ID_EX_rd, hz.IF_ID_rt));
  assign dep_mem = reg_match(hz.EX_MEM_rd, hz.IF_ID_rs) ||
                   (hz.uses_rt && reg_match(hz.EX_MEM_rd, hz.IF_ID_rt));

  always_comb begin
    hazard             = '0;
    hazard.br_load_ex  = hz.branch && hz.ID_EX_mem_read && dep_ex;
    hazard.br_alu_ex   = hz.branch && hz.ID_EX_reg_write &&
                         !hz.ID_EX_mem_read && dep_ex;
    hazard.br_load_mem = hz.branch && hz.EX_MEM_mem_read && dep_mem;
    // A branch consumer is fully covered by the branch rules above.
    hazard.load_use    = !hz.branch && hz.ID_EX_mem_read && dep_ex;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      RUN: begin
        if (hazard.br_load_ex) begin
          // Load data reaches forwarding only after MEM, so the branch must
          // wait two cycles; HOLD supplies the second one.
          stall      = 1'b1;
          state_next = HOLD;
        end else if (hazard.br_alu_ex || hazard.br_load_mem ||
                     hazard.load_use) begin
          stall      = 1'b1;
          state_next = RUN;
        end else begin
          // Only a branch that is actually evaluated this cycle may squash
          // the wrong-path fetch; a stalled branch's compare is stale.
          flush      = hz.branch && hz.branch_taken;
          state_next = RUN;
        end
      end
      HOLD: begin
        stall      = 1'b1;
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Reset overrides the controls: freeze fetch and feed bubbles downstream.
  always_comb begin
    if (!rstn) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EX_bubble = 1'b1;
      hz.IF_ID_flush  = 1'b0;
    end else begin
      hz.pc_write     = !stall;
      hz.IF_ID_write  = !stall;
      hz.ID_EX_bubble = stall;
      hz.IF_ID_flush  = flush;
    end
  end

  // Counter 0 tracks stall cycles, counter 1 tracks flush cycles.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = rstn && stall;
  assign cnt_inc[1] = hz.IF_ID_flush;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign hz.stall_count = cnt_val[0];
  assign hz.flush_count = cnt_val[1];

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first, as listed in REQ-002 to REQ-019.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 IF_ID_rs  input  5  rs of the instruction in ID.
REQ-005 IF_ID_rt  input  5  rt of the instruction in ID.
REQ-006 uses_rt  input  1  ID instruction reads rt (R-type, beq, bne, sw).
REQ-007 branch  input  1  ID instruction is a branch resolved in ID.
REQ-008 branch_taken  input  1  ID compare result, using forwarded operands.
REQ-009 ID_EX_mem_read  input  1  EX instruction is a load.
REQ-010 ID_EX_reg_write  input  1  EX instruction writes a register.
REQ-011 ID_EX_rd  input  5  EX destination, after the reg_dst mux.
REQ-012 EX_MEM_mem_read  input  1  MEM instruction is a load.
REQ-013 EX_MEM_rd  input  5  MEM destination.
REQ-014 pc_write  output  1  PC update enable.
REQ-015 IF_ID_write  output  1  IF/ID register update enable.
REQ-016 ID_EX_bubble  output  1  zero the ID/EX control fields (insert nop).
REQ-017 IF_ID_flush  output  1  zero the IF/ID instruction (squash wrong-path fetch).
REQ-018 stall_count  output  16  saturating count of stall cycles.
REQ-019 flush_count  output  16  saturating count of flush cycles.

Function
REQ-020 Match definitions: mEX(r) = (ID_EX_rd==r && r!=0); mMEM(r) = (EX_MEM_rd==r && r!=0); dep(m) = m(IF_ID_rs) || (uses_rt && m(IF_ID_rt)).
REQ-021 FSM states: RUN and HOLD; reset state RUN.
REQ-022 RUN, load-use: ID_EX_mem_read && dep(mEX) and !branch -> stall this cycle; next state RUN.
REQ-023 RUN, branch on an ALU result in EX: branch && ID_EX_reg_write && !ID_EX_mem_read && dep(mEX) -> stall this cycle; next state RUN.
REQ-024 RUN, branch on a load in EX: branch && ID_EX_mem_read && dep(mEX) -> stall this cycle; next state HOLD.
REQ-025 RUN, branch on a load in MEM: branch && EX_MEM_mem_read && dep(mMEM) -> stall this cycle; next state RUN.
REQ-026 HOLD: unconditional stall, no hazard evaluation; next state RUN.
REQ-027 Stall cycle: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
REQ-028 Non-stall cycle in RUN: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush = branch && branch_taken.
REQ-029 branch_taken SHALL be ignored in any stall cycle; a stall always takes priority over a flush.
REQ-030 Outputs REQ-027/028 SHALL be combinational from state and inputs; zero added latency.
REQ-031 stall_count SHALL increment at each clock edge that ends a stall cycle, and hold at 16'hFFFF.
REQ-032 flush_count SHALL increment at each clock edge where IF_ID_flush=1, and saturate the same way.
REQ-033 Several hazard conditions true at once SHALL resolve in order REQ-024 > REQ-023 > REQ-025 > REQ-022; only REQ-024 enters HOLD.

Reset
REQ-034 rstn=0 SHALL immediately set state to RUN and both counters to 0, independent of clk.
REQ-035 While rstn=0: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
REQ-036 Reset asserted in HOLD SHALL abandon the pending stall; the first cycle after release evaluates as RUN.

Structure
REQ-037 Package hazard_pkg SHALL hold the state encoding (RUN=1'b0, HOLD=1'b1) and CNT_W=16.
REQ-038 Sub-module sat_counter (parameter W; inputs clk, rstn, inc; output count) SHALL be instantiated twice, once per counter.

Verification
REQ-039 lw $2 in EX; add in ID reads rs=$2 -> one stall (pc_write=0, ID_EX_bubble=1), then RUN; stall_count=1.
REQ-040 lw $3 in EX; beq $3,$0 in ID -> two consecutive stall cycles (RUN->HOLD->RUN); stall_count=2.
REQ-041 add $4 in EX; beq $1,$4 in ID, taken -> one stall with IF_ID_flush=0; next cycle IF_ID_flush=1; flush_count=1.
REQ-042 ID_EX_rd=0, ID_EX_mem_read=1, IF_ID_rs=0 -> no stall; uses_rt=0 with rt match alone -> no stall.
REQ-043 rstn pulsed low mid-HOLD -> counters read 0, state RUN; pc_write=1 on the first idle cycle after release.
REQ-044 Preload stall_count to 16'hFFFE, force 3 stall cycles -> count reads 16'hFFFF and stays there.
